seg_scan: RTL

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan.sv | 85 ++++++++
 1 files changed

// File: rtl/seg_scan.sv
// seg_scan: four-digit multiplexed 7-segment scanner with frame-shadowed digits and decimal points.
// Optional per-digit blinking is enabled by defining SEG_BLINK_EN.
module seg_scan #(
  parameter int DIV       = 100000,
  parameter int GUARD     = 16,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   sh_digits;
  logic [3:0]    sh_dp;
  logic [3:0]    dig;
  logic [6:0]    seg_d;
  logic          wrap, load, blank;
  assign wrap = cnt == CW'(DIV - 1);
  assign load = wrap && idx == 2'd0;
  assign dig  = sh_digits[{idx, 2'b00} +: 4];
  always_comb begin
    case (dig)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'b1111111;
    endcase
  end
`ifdef SEG_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);
  logic [BW-1:0] bcnt;
  logic          phase;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else begin
      bcnt  <= bcnt == BW'(BLINK_DIV - 1) ? '0 : bcnt + 1'b1;
      phase <= bcnt == BW'(BLINK_DIV - 1) ? ~phase : phase;
    end
  end
  // blink_mask is deliberately unshadowed so a blink request shows up at once
  assign blank = cnt < CW'(GUARD) || (phase && blink_mask[idx]);
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask ^ (BLINK_DIV > 0);
  assign blank = cnt < CW'(GUARD);
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= 2'd3;
      sh_digits  <= '0;
      sh_dp      <= '0;
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= wrap ? '0 : cnt + 1'b1;
      idx        <= wrap ? idx - 1'b1 : idx;
      frame_tick <= load;
      sh_digits  <= load ? digits : sh_digits;
      sh_dp      <= load ? dp_mask : sh_dp;
      an         <= blank ? 4'hF : ~(4'b0001 << idx);
      seg        <= blank ? 7'h7F : seg_d;
      dp         <= blank | ~sh_dp[idx];
    end
  end
endmodule
